fp_mul_arbiter: RTL and testbench
=================================

// Module: fp_mul_arbiter
// PURPOSE
//   Shares one pipelined single-precision multiplier (fp_X*fp_Y->fp_Z, r_mode, ovrf, udrf)
//   between two requesters, A and B.
//   - Round-robin grant, at most one issue per cycle.
//   - Tracks the requester ID of each in-flight operation in a tag pipeline.
//   - Routes each registered result back to the requester that issued it.
//   - Sits between the FPU issue logic and the multiplier datapath.
// PARAMETERS
//   MUL_LAT   3   multiplier latency in cycles, operands in -> fp_Z out; legal range 1..8
// PORTS
//   clk           in   1   clock; all state updates on rising edge
//   rst           in   1   synchronous, active-high reset
//   a_vld         in   1   requester A has an operation
//   a_rdy         out  1   A granted this cycle; transfer when a_vld && a_rdy
//   a_X, a_Y      in   32  A operands
//   a_r_mode      in   3   A rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM)
//   b_vld/b_rdy/b_X/b_Y/b_r_mode   same as A, for requester B
//   mul_vld       out  1   issue strobe to multiplier
//   mul_X, mul_Y  out  32  operands to multiplier
//   mul_r_mode    out  3   rounding mode to multiplier
//   mul_vld_o     in   1   multiplier output-valid, MUL_LAT cycles after mul_vld
//   mul_Z         in   32  multiplier result
//   mul_ovrf      in   1   multiplier overflow flag
//   mul_udrf      in   1   multiplier underflow flag
//   a_rsp_vld     out  1   result for A valid, one-cycle pulse, no backpressure
//   a_Z           out  32  result for A
//   a_ovrf, a_udrf out 1   flags for A
//   b_rsp_vld/b_Z/b_ovrf/b_udrf    same as A, for requester B
//   inflight      out  4   number of issued operations not yet returned (0..MUL_LAT)
//   tag_err       out  1   sticky: mul_vld_o disagreed with the tag pipeline
// BEHAVIOUR
//   Reset (rst=1 at a clock edge; overrides everything else):
//   - a_rsp_vld=b_rsp_vld=0; a_Z/b_Z/flags=0; inflight=0; tag_err=0.
//   - All tag-pipeline stages cleared; rr_last=B, so A wins the first tie.
//   - Operations already in flight are discarded; no rsp_vld ever pulses for them.
//   - a_rdy=b_rdy=0 while rst=1.
//   Arbitration (combinational, same cycle):
//   - Only a_vld set -> grant A. Only b_vld set -> grant B.
//   - Both set -> grant the requester != rr_last.
//   - a_rdy and b_rdy are one-hot or zero; rdy never asserts without its vld.
//   - On a grant, rr_last <= granted ID; with no grant, rr_last holds.
//   - A requester holding vld under contention is served within 2 cycles (no starvation).
//   Issue (combinational):
//   - mul_vld = a_rdy|b_rdy.
//   - mul_X/mul_Y/mul_r_mode = operands of the granted requester.
//   - With no grant, mul operands are all zero.
//   Tag pipeline:
//   - MUL_LAT stages of {vld, id}; stage0 <= {mul_vld, granted_id}; shifts every cycle.
//   - There is no stall path.
//   Return:
//   - When the final tag stage is valid, the result is registered next edge:
//     {id}_rsp_vld <= 1, {id}_Z <= mul_Z, {id}_ovrf <= mul_ovrf, {id}_udrf <= mul_udrf.
//   - The other requester's rsp_vld <= 0 and its data holds.
//   - Total latency: handshake at cycle t -> rsp_vld at cycle t+MUL_LAT+1.
//   - Results return in issue order; throughput is 1 result per cycle.
//   Counter and error:
//   - inflight = count of valid tag stages; it increments and decrements in the same cycle
//     without error, and equals MUL_LAT under back-to-back issue.
//   - tag_err <= 1 when mul_vld_o != final-stage vld; it clears only on rst.
//   - The result is still routed per the tag when tag_err sets.
// TESTING
//   1. A only: X=0x40400000, Y=0x40400000, r_mode=001 at t=0
//      -> a_rsp_vld at t=MUL_LAT+1, a_Z=0x41100000, ovrf=udrf=0; b_rsp_vld stays 0.
//   2. a_vld and b_vld both set from the first cycle after reset
//      -> grants A,B,A,B...; responses alternate in the same order; inflight=MUL_LAT.
//   3. B only, X=0x20000000, Y=0x1F800000, r_mode=001
//      -> b_Z=0x00400000 after MUL_LAT+1 cycles; no a_rsp_vld.
//   4. Issue 3 ops back-to-back, assert rst for 1 cycle at t=1
//      -> no rsp_vld pulses afterwards; inflight=0; next A issue wins the tie.
//   5. Force mul_vld_o=1 with no op in flight
//      -> tag_err=1 next cycle and stays 1 until rst.
//   6. A holds a_vld, B pulses b_vld every 3rd cycle -> B is granted on each pulse cycle
//      where rr_last=A; A never waits more than 1 cycle.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin sharing of one pipelined fp multiplier between two requesters
//
// Purpose: arbitrates requesters A and B onto a single pipelined single-precision
// multiplier, remembers who issued each in-flight operation in a tag pipeline and
// steers every registered result back to its issuer.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   a_vld/a_rdy/a_X/a_Y/a_r_mode  requester A issue handshake and operands
//   b_vld/b_rdy/b_X/b_Y/b_r_mode  requester B issue handshake and operands
//   mul_vld/mul_X/mul_Y/mul_r_mode issue to multiplier
//   mul_vld_o/mul_Z/mul_ovrf/mul_udrf result from multiplier, MUL_LAT cycles after issue
//   a_rsp_vld/a_Z/a_ovrf/a_udrf   registered result pulse for A
//   b_rsp_vld/b_Z/b_ovrf/b_udrf   registered result pulse for B
//   inflight                      issued operations not yet returned
//   tag_err                       sticky: multiplier valid disagreed with tag pipeline
module fp_mul_arbiter #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_vld,
  output logic        a_rdy,
  input  logic [31:0] a_X,
  input  logic [31:0] a_Y,
  input  logic [2:0]  a_r_mode,
  input  logic        b_vld,
  output logic        b_rdy,
  input  logic [31:0] b_X,
  input  logic [31:0] b_Y,
  input  logic [2:0]  b_r_mode,
  output logic        mul_vld,
  output logic [31:0] mul_X,
  output logic [31:0] mul_Y,
  output logic [2:0]  mul_r_mode,
  input  logic        mul_vld_o,
  input  logic [31:0] mul_Z,
  input  logic        mul_ovrf,
  input  logic        mul_udrf,
  output logic        a_rsp_vld,
  output logic [31:0] a_Z,
  output logic        a_ovrf,
  output logic        a_udrf,
  output logic        b_rsp_vld,
  output logic [31:0] b_Z,
  output logic        b_ovrf,
  output logic        b_udrf,
  output logic [3:0]  inflight,
  output logic        tag_err
);

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  logic               rr_last_q;
  logic [MUL_LAT-1:0] tag_vld_q;
  logic [MUL_LAT-1:0] tag_id_q;
  logic               a_rsp_vld_q, b_rsp_vld_q;
  logic [31:0]        a_z_q, b_z_q;
  logic               a_ovrf_q, a_udrf_q, b_ovrf_q, b_udrf_q;
  logic               tag_err_q;
  logic [3:0]         inflight_d;
  logic               fin_vld, fin_id;

  // On contention the requester that did not win last time gets the slot.
  assign a_rdy = !rst && a_vld && (!b_vld || (rr_last_q == ID_B));
  assign b_rdy = !rst && b_vld && (!a_vld || (rr_last_q == ID_A));

  assign mul_vld    = a_rdy | b_rdy;
  assign mul_X      = a_rdy ? a_X      : (b_rdy ? b_X      : 32'd0);
  assign mul_Y      = a_rdy ? a_Y      : (b_rdy ? b_Y      : 32'd0);
  assign mul_r_mode = a_rdy ? a_r_mode : (b_rdy ? b_r_mode : 3'd0);

  assign fin_vld = tag_vld_q[MUL_LAT-1];
  assign fin_id  = tag_id_q[MUL_LAT-1];

  always_comb begin
    inflight_d = 4'd0;
    for (int i = 0; i < MUL_LAT; i++) begin
      inflight_d = inflight_d + {3'd0, tag_vld_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q   <= ID_B;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      a_rsp_vld_q <= 1'b0;
      b_rsp_vld_q <= 1'b0;
      a_z_q       <= 32'd0;
      b_z_q       <= 32'd0;
      a_ovrf_q    <= 1'b0;
      a_udrf_q    <= 1'b0;
      b_ovrf_q    <= 1'b0;
      b_udrf_q    <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      if (mul_vld) begin
        rr_last_q <= b_rdy ? ID_B : ID_A;
      end

      // Fixed-length shift with no stall: the tag lines up with mul_vld_o.
      tag_vld_q[0] <= mul_vld;
      tag_id_q[0]  <= b_rdy;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end

      // Results follow the tag even when the multiplier strobe disagrees.
      a_rsp_vld_q <= fin_vld && (fin_id == ID_A);
      b_rsp_vld_q <= fin_vld && (fin_id == ID_B);
      if (fin_vld && (fin_id == ID_A)) begin
        a_z_q    <= mul_Z;
        a_ovrf_q <= mul_ovrf;
        a_udrf_q <= mul_udrf;
      end
      if (fin_vld && (fin_id == ID_B)) begin
        b_z_q    <= mul_Z;
        b_ovrf_q <= mul_ovrf;
        b_udrf_q <= mul_udrf;
      end

      if (mul_vld_o != fin_vld) begin
        tag_err_q <= 1'b1;
      end
    end
  end

  assign a_rsp_vld = a_rsp_vld_q;
  assign a_Z       = a_z_q;
  assign a_ovrf    = a_ovrf_q;
  assign a_udrf    = a_udrf_q;
  assign b_rsp_vld = b_rsp_vld_q;
  assign b_Z       = b_z_q;
  assign b_ovrf    = b_ovrf_q;
  assign b_udrf    = b_udrf_q;
  assign inflight  = inflight_d;
  assign tag_err   = tag_err_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - scoreboard bench for fp_mul_arbiter
module tb_fp_mul_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_vld, b_vld;
  logic        a_rdy, b_rdy;
  logic [31:0] a_X, a_Y, b_X, b_Y;
  logic [2:0]  a_r_mode, b_r_mode;
  logic        mul_vld;
  logic [31:0] mul_X, mul_Y;
  logic [2:0]  mul_r_mode;
  logic        mul_vld_o;
  logic [31:0] mul_Z;
  logic        mul_ovrf, mul_udrf;
  logic        a_rsp_vld, a_ovrf, a_udrf;
  logic        b_rsp_vld, b_ovrf, b_udrf;
  logic [31:0] a_Z, b_Z;
  logic [3:0]  inflight;
  logic        tag_err;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .a_vld(a_vld), .a_rdy(a_rdy), .a_X(a_X), .a_Y(a_Y), .a_r_mode(a_r_mode),
    .b_vld(b_vld), .b_rdy(b_rdy), .b_X(b_X), .b_Y(b_Y), .b_r_mode(b_r_mode),
    .mul_vld(mul_vld), .mul_X(mul_X), .mul_Y(mul_Y), .mul_r_mode(mul_r_mode),
    .mul_vld_o(mul_vld_o), .mul_Z(mul_Z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
    .a_rsp_vld(a_rsp_vld), .a_Z(a_Z), .a_ovrf(a_ovrf), .a_udrf(a_udrf),
    .b_rsp_vld(b_rsp_vld), .b_Z(b_Z), .b_ovrf(b_ovrf), .b_udrf(b_udrf),
    .inflight(inflight), .tag_err(tag_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stand-in multiplier: exact answers for the directed operand pairs, a
  // deterministic scramble otherwise so routing errors stay visible.
  function automatic logic [33:0] mul_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] rm);
    if (x == 32'h40400000 && y == 32'h40400000) return {2'b00, 32'h41100000};
    if (x == 32'h20000000 && y == 32'h1F800000) return {2'b00, 32'h00400000};
    return {x[3] ^ y[7], x[9], x ^ {y[15:0], y[31:16]} ^ {29'd0, rm}};
  endfunction

  logic [LAT-1:0] p_vld;
  logic [33:0]    p_res [LAT];
  logic           force_vo;

  always @(posedge clk) begin
    if (rst) begin
      p_vld <= '0;
      for (int i = 0; i < LAT; i++) p_res[i] <= '0;
    end else begin
      p_vld[0] <= mul_vld;
      p_res[0] <= mul_fn(mul_X, mul_Y, mul_r_mode);
      for (int i = 1; i < LAT; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_res[i] <= p_res[i-1];
      end
    end
  end

  assign mul_vld_o = p_vld[LAT-1] | force_vo;
  assign mul_Z     = p_res[LAT-1][31:0];
  assign mul_ovrf  = p_res[LAT-1][33];
  assign mul_udrf  = p_res[LAT-1][32];

  typedef struct {
    logic        id;
    int          due;
    logic [33:0] res;
  } sb_t;

  sb_t  q[$];
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic exp_rr = 1'b1;
  logic exp_terr = 1'b0;
  logic [33:0] exp_ar = '0, exp_br = '0;
  int   a_wait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      logic ea, eb, front, fin;
      sb_t  e;
      ea = !rst && a_vld && (!b_vld || exp_rr);
      eb = !rst && b_vld && (!a_vld || !exp_rr);
      check("a_rdy", a_rdy, ea);
      check("b_rdy", b_rdy, eb);
      check("mul_vld", mul_vld, ea | eb);
      check("mul_X", mul_X, ea ? a_X : (eb ? b_X : 32'd0));
      check("mul_Y", mul_Y, ea ? a_Y : (eb ? b_Y : 32'd0));
      check("mul_r_mode", mul_r_mode, ea ? a_r_mode : (eb ? b_r_mode : 3'd0));

      front = (q.size() > 0) && (q[0].due == cyc);
      if (front) begin
        e = q.pop_front();
        if (e.id) exp_br = e.res; else exp_ar = e.res;
      end
      check("a_rsp_vld", a_rsp_vld, front && !e.id);
      check("b_rsp_vld", b_rsp_vld, front && e.id);
      check("a_result", {a_ovrf, a_udrf, a_Z}, exp_ar);
      check("b_result", {b_ovrf, b_udrf, b_Z}, exp_br);
      check("inflight", inflight, q.size());
      check("tag_err", tag_err, exp_terr);

      fin = (q.size() > 0) && (q[0].due == cyc + 1);
      if (!rst && (mul_vld_o != fin)) exp_terr = 1'b1;

      if (ea) q.push_back('{1'b0, cyc + LAT + 1, mul_fn(a_X, a_Y, a_r_mode)});
      if (eb) q.push_back('{1'b1, cyc + LAT + 1, mul_fn(b_X, b_Y, b_r_mode)});
      if (ea) exp_rr = 1'b0;
      if (eb) exp_rr = 1'b1;

      if (!rst && a_vld) begin
        a_wait = ea ? 0 : a_wait + 1;
        check("a_wait_le1", a_wait <= 1, 1);
      end else begin
        a_wait = 0;
      end

      if (rst) begin
        q.delete();
        exp_rr   = 1'b1;
        exp_terr = 1'b0;
        exp_ar   = '0;
        exp_br   = '0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_a(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] rm);
    a_vld = v; a_X = x; a_Y = y; a_r_mode = rm;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] rm);
    b_vld = v; b_X = x; b_Y = y; b_r_mode = rm;
  endtask

  task automatic rand_a(input logic v);
    drive_a(v, $urandom, $urandom, 3'($urandom_range(0, 4)));
  endtask

  task automatic rand_b(input logic v);
    drive_b(v, $urandom, $urandom, 3'($urandom_range(0, 4)));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    force_vo = 1'b0;
    drive_a(1'b0, 32'd0, 32'd0, 3'd0);
    drive_b(1'b0, 32'd0, 32'd0, 3'd0);
    step(1);
    mon_en = 1'b1;
    step(1);
    rst = 1'b0;

    // A only, 3.0 * 3.0
    drive_a(1'b1, 32'h40400000, 32'h40400000, 3'b001);
    step(1);
    drive_a(1'b0, 32'd0, 32'd0, 3'd0);
    step(LAT + 3);

    // Both requesting from the first cycle after reset
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      rand_a(1'b1);
      rand_b(1'b1);
      step(1);
    end
    drive_a(1'b0, 32'd0, 32'd0, 3'd0);
    drive_b(1'b0, 32'd0, 32'd0, 3'd0);
    step(LAT + 3);

    // B only, denormal product
    drive_b(1'b1, 32'h20000000, 32'h1F800000, 3'b001);
    step(1);
    drive_b(1'b0, 32'd0, 32'd0, 3'd0);
    step(LAT + 3);

    // Back-to-back issue with reset in the middle, then a tie
    rand_a(1'b1);
    rand_b(1'b1);
    step(1);
    rst = 1'b1;
    rand_a(1'b1);
    step(1);
    rst = 1'b0;
    rand_a(1'b1);
    rand_b(1'b0);
    step(1);
    do_reset(1);
    rand_a(1'b1);
    rand_b(1'b1);
    step(1);
    drive_a(1'b0, 32'd0, 32'd0, 3'd0);
    drive_b(1'b0, 32'd0, 32'd0, 3'd0);
    step(LAT + 3);

    // Spurious multiplier valid with nothing in flight
    force_vo = 1'b1;
    step(1);
    force_vo = 1'b0;
    step(5);
    do_reset(1);
    step(2);

    // A holds vld, B pulses every third cycle
    for (int i = 0; i < 15; i++) begin
      rand_a(1'b1);
      rand_b(i % 3 == 2);
      step(1);
    end
    drive_a(1'b0, 32'd0, 32'd0, 3'd0);
    drive_b(1'b0, 32'd0, 32'd0, 3'd0);
    step(LAT + 3);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      rand_a(1'($urandom_range(0, 1)));
      rand_b(1'($urandom_range(0, 1)));
      step(1);
    end
    drive_a(1'b0, 32'd0, 32'd0, 3'd0);
    drive_b(1'b0, 32'd0, 32'd0, 3'd0);
    step(LAT + 4);

    check("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
